mem_wb_stage: RTL and testbench

- Pipeline register between the memory stage and the register-file writeback stage.
- Captures the MEM-stage result bundle and aligns and sign/zero-extends load data from data memory into a word (dmem_out).
- Stalls the pipeline while a load response is outstanding.
- Presents the WB-side signals, including CSR writeback fields, that the register file consumes one cycle later.

---
 rtl/mem_wb_stage_pkg.sv | 20 ++
 rtl/mem_wb_stage_if.sv | 52 +++++
 rtl/mem_wb_stage_load_align.sv | 41 ++++
 rtl/mem_wb_stage.sv | 153 +++++++++++++++
 tb/tb_mem_wb_stage.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_wb_stage_pkg.sv
// Shared MEM/WB definitions: writeback select codes, load funct3 codes
// and the load-wait FSM encoding.
package mem_wb_stage_pkg;

    localparam logic [1:0] WB_DMEM = 2'd0;
    localparam logic [1:0] WB_ALU  = 2'd1;
    localparam logic [1:0] WB_PC4  = 2'd2;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic {
        ST_IDLE      = 1'b0,
        ST_WAIT_LOAD = 1'b1
    } state_t;

endpackage

// File: rtl/mem_wb_stage_if.sv
// MEM-side bundle, data-memory response and WB-side outputs of the
// MEM/WB pipeline register.
interface mem_wb_stage_if;

    logic        M_valid;
    logic        M_is_load;
    logic        M_reg_wen;
    logic [4:0]  M_rd;
    logic [1:0]  M_WBSel;
    logic [2:0]  M_funct3;
    logic [31:0] M_PC;
    logic [31:0] M_ALU_out;
    logic        M_csr_reg_en;
    logic [31:0] M_csr_rresult;
    logic [31:0] M_csr_data;
    logic [11:0] M_csr_addr;
    logic        flush;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;

    logic        mem_stall;
    logic        load_fault;
    logic        WB_write_enable;
    logic [4:0]  WB_rd;
    logic [1:0]  WB_WBSel;
    logic [31:0] WB_PC;
    logic [31:0] WB_ALU_out;
    logic [31:0] WB_dmem_out;
    logic        WB_csr_reg_en;
    logic [31:0] WB_csr_rresult;
    logic [31:0] WB_csr_data_to_wb;
    logic [31:0] WB_csr_addr_to_wb;

    modport master (
        output M_valid, M_is_load, M_reg_wen, M_rd, M_WBSel, M_funct3, M_PC,
               M_ALU_out, M_csr_reg_en, M_csr_rresult, M_csr_data, M_csr_addr,
               flush, dmem_rvalid, dmem_rdata,
        input  mem_stall, load_fault, WB_write_enable, WB_rd, WB_WBSel, WB_PC,
               WB_ALU_out, WB_dmem_out, WB_csr_reg_en, WB_csr_rresult,
               WB_csr_data_to_wb, WB_csr_addr_to_wb
    );

    modport slave (
        input  M_valid, M_is_load, M_reg_wen, M_rd, M_WBSel, M_funct3, M_PC,
               M_ALU_out, M_csr_reg_en, M_csr_rresult, M_csr_data, M_csr_addr,
               flush, dmem_rvalid, dmem_rdata,
        output mem_stall, load_fault, WB_write_enable, WB_rd, WB_WBSel, WB_PC,
               WB_ALU_out, WB_dmem_out, WB_csr_reg_en, WB_csr_rresult,
               WB_csr_data_to_wb, WB_csr_addr_to_wb
    );

endinterface

// File: rtl/mem_wb_stage_load_align.sv
// Picks the addressed byte/half out of a raw memory word and sign- or
// zero-extends it according to the load funct3.
module mem_wb_stage_load_align
    import mem_wb_stage_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_data
);

    logic signed [7:0]  w_byte;
    logic signed [15:0] w_half;

    function automatic logic [31:0] sext8(input logic signed [7:0] v);
        logic signed [31:0] ext;
        ext = v;
        return ext;
    endfunction

    function automatic logic [31:0] sext16(input logic signed [15:0] v);
        logic signed [31:0] ext;
        ext = v;
        return ext;
    endfunction

    always_comb begin
        w_byte = i_rdata[{i_off, 3'b000} +: 8];
        // Halfword loads ignore off[0]: no misalignment trap exists.
        w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];
        case (i_funct3)
            F3_LB:   o_data = sext8(w_byte);
            F3_LBU:  o_data = {24'd0, w_byte};
            F3_LH:   o_data = sext16(w_half);
            F3_LHU:  o_data = {16'd0, w_half};
            F3_LW:   o_data = i_rdata;
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: captures the MEM bundle, aligns load data and
// stalls upstream while a data-memory response is outstanding.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int LOAD_TIMEOUT = 16,
    parameter int CNT_W        = 5
) (
    input  logic          clk,
    input  logic          rst,
    mem_wb_stage_if.slave bus
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_kill;
    logic             w_kill_nxt;

    logic        w_miss;
    logic        w_timeout;
    logic        w_stall;
    logic        w_capture;
    logic        w_fault;
    logic [31:0] w_aligned;

    logic        r_we;
    logic        r_csr_en;
    logic        r_fault;
    logic [4:0]  r_rd;
    logic [1:0]  r_wbsel;
    logic [31:0] r_pc;
    logic [31:0] r_alu;
    logic [31:0] r_dmem;
    logic [31:0] r_csr_rres;
    logic [31:0] r_csr_data;
    logic [11:0] r_csr_addr;

    assign w_miss    = bus.M_valid && bus.M_is_load && !bus.dmem_rvalid;
    assign w_timeout = (r_cnt == CNT_W'(LOAD_TIMEOUT));

    mem_wb_stage_load_align u_align (
        .i_funct3 (bus.M_funct3),
        .i_off    (bus.M_ALU_out[1:0]),
        .i_rdata  (bus.dmem_rdata),
        .o_data   (w_aligned)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_kill  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_kill  <= w_kill_nxt;
        end
    end

    // A flushed load still waits for its response so that a late rvalid
    // is consumed here instead of being credited to the next load.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_kill_nxt  = r_kill;
        case (r_state)
            ST_IDLE: begin
                if (w_miss) begin
                    w_state_nxt = ST_WAIT_LOAD;
                    w_cnt_nxt   = CNT_W'(1);
                    w_kill_nxt  = bus.flush;
                end
            end
            ST_WAIT_LOAD: begin
                if (bus.dmem_rvalid || w_timeout) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                    w_kill_nxt  = 1'b0;
                end else begin
                    w_cnt_nxt   = r_cnt + 1'b1;
                    w_kill_nxt  = r_kill || bus.flush;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_stall   = 1'b0;
        w_capture = 1'b0;
        w_fault   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_stall   = w_miss;
                w_capture = bus.M_valid && !bus.flush &&
                            (!bus.M_is_load || bus.dmem_rvalid);
            end
            ST_WAIT_LOAD: begin
                // A response arriving in the timeout cycle still wins.
                w_stall   = !bus.dmem_rvalid && !w_timeout;
                w_capture = bus.dmem_rvalid && !r_kill && !bus.flush;
                w_fault   = !bus.dmem_rvalid && w_timeout;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_we       <= 1'b0;
            r_csr_en   <= 1'b0;
            r_fault    <= 1'b0;
            r_rd       <= '0;
            r_wbsel    <= '0;
            r_pc       <= '0;
            r_alu      <= '0;
            r_dmem     <= '0;
            r_csr_rres <= '0;
            r_csr_data <= '0;
            r_csr_addr <= '0;
        end else begin
            r_we     <= w_capture && bus.M_reg_wen && (bus.M_rd != 5'd0);
            r_csr_en <= w_capture && bus.M_csr_reg_en;
            r_fault  <= w_fault;
            if (w_capture) begin
                r_rd       <= bus.M_rd;
                r_wbsel    <= bus.M_WBSel;
                r_pc       <= bus.M_PC;
                r_alu      <= bus.M_ALU_out;
                r_dmem     <= w_aligned;
                r_csr_rres <= bus.M_csr_rresult;
                r_csr_data <= bus.M_csr_data;
                r_csr_addr <= bus.M_csr_addr;
            end
        end
    end

    assign bus.mem_stall         = w_stall;
    assign bus.load_fault        = r_fault;
    assign bus.WB_write_enable   = r_we;
    assign bus.WB_rd             = r_rd;
    assign bus.WB_WBSel          = r_wbsel;
    assign bus.WB_PC             = r_pc;
    assign bus.WB_ALU_out        = r_alu;
    assign bus.WB_dmem_out       = r_dmem;
    assign bus.WB_csr_reg_en     = r_csr_en;
    assign bus.WB_csr_rresult    = r_csr_rres;
    assign bus.WB_csr_data_to_wb = r_csr_data;
    assign bus.WB_csr_addr_to_wb = {20'd0, r_csr_addr};

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed and randomized bench for mem_wb_stage against a cycle-level
// behavioural model of the MEM/WB register.
module tb_mem_wb_stage;
    import mem_wb_stage_pkg::*;

    localparam int LOAD_TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst;
    int   n_vec  = 0;
    int   n_fail = 0;

    mem_wb_stage_if bus();

    mem_wb_stage #(.LOAD_TIMEOUT(LOAD_TIMEOUT), .CNT_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench did not finish");
    end

    // Behavioural model state
    bit          m_pending;
    bit          m_killed;
    int          m_age;
    logic        e_we, e_csr_en, e_fault;
    logic [4:0]  e_rd;
    logic [1:0]  e_sel;
    logic [31:0] e_pc, e_alu, e_dmem, e_rres, e_cdata, e_caddr;
    logic        last_stall;

    logic [2:0]  lf3  [5] = '{F3_LB, F3_LB, F3_LBU, F3_LH, F3_LHU};
    logic [1:0]  loff [5] = '{2'd1, 2'd3, 2'd2, 2'd2, 2'd0};
    logic [31:0] lexp [5] = '{32'h0000_007F, 32'hFFFF_FF80, 32'h0000_00FF,
                              32'hFFFF_80FF, 32'h0000_7F01};

    function automatic logic [31:0] ref_align(input logic [2:0] f3,
                                              input logic [31:0] addr,
                                              input logic [31:0] rd);
        logic [31:0] off, b, h;
        off = addr % 32'd4;
        b   = (rd / (32'd1 << (32'd8 * off))) % 32'd256;
        h   = (rd / (32'd1 << (32'd16 * (off / 32'd2)))) % 32'd65536;
        case (f3)
            3'b000:  return (b >= 32'd128) ? b - 32'd256 : b;
            3'b100:  return b;
            3'b001:  return (h >= 32'd32768) ? h - 32'd65536 : h;
            3'b101:  return h;
            default: return rd;
        endcase
    endfunction

    function automatic logic model_stall();
        if (!m_pending)
            return bus.M_valid && bus.M_is_load && !bus.dmem_rvalid;
        return !bus.dmem_rvalid && (m_age < LOAD_TIMEOUT);
    endfunction

    task automatic model_reset();
        m_pending = 0; m_killed = 0; m_age = 0;
        e_we = 0; e_csr_en = 0; e_fault = 0; e_rd = '0; e_sel = '0;
        e_pc = '0; e_alu = '0; e_dmem = '0; e_rres = '0; e_cdata = '0; e_caddr = '0;
    endtask

    task automatic model_edge();
        bit commit;
        commit  = 0;
        e_fault = 0;
        if (rst) begin
            model_reset();
            return;
        end
        if (!m_pending) begin
            if (bus.M_valid && bus.M_is_load && !bus.dmem_rvalid) begin
                m_pending = 1; m_age = 1; m_killed = bus.flush;
            end else begin
                commit = bus.M_valid && !bus.flush;
            end
        end else if (bus.dmem_rvalid) begin
            commit    = !m_killed && !bus.flush;
            m_pending = 0;
        end else if (m_age >= LOAD_TIMEOUT) begin
            e_fault   = 1;
            m_pending = 0;
        end else begin
            m_age++;
            m_killed = m_killed | bus.flush;
        end
        e_we     = commit && bus.M_reg_wen && (bus.M_rd != 5'd0);
        e_csr_en = commit && bus.M_csr_reg_en;
        if (commit) begin
            e_rd    = bus.M_rd;
            e_sel   = bus.M_WBSel;
            e_pc    = bus.M_PC;
            e_alu   = bus.M_ALU_out;
            e_dmem  = ref_align(bus.M_funct3, bus.M_ALU_out, bus.dmem_rdata);
            e_rres  = bus.M_csr_rresult;
            e_cdata = bus.M_csr_data;
            e_caddr = {20'd0, bus.M_csr_addr};
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("WB_write_enable", 32'(bus.WB_write_enable), 32'(e_we));
        chk("WB_rd", 32'(bus.WB_rd), 32'(e_rd));
        chk("WB_WBSel", 32'(bus.WB_WBSel), 32'(e_sel));
        chk("WB_PC", bus.WB_PC, e_pc);
        chk("WB_ALU_out", bus.WB_ALU_out, e_alu);
        chk("WB_dmem_out", bus.WB_dmem_out, e_dmem);
        chk("WB_csr_reg_en", 32'(bus.WB_csr_reg_en), 32'(e_csr_en));
        chk("WB_csr_rresult", bus.WB_csr_rresult, e_rres);
        chk("WB_csr_data_to_wb", bus.WB_csr_data_to_wb, e_cdata);
        chk("WB_csr_addr_to_wb", bus.WB_csr_addr_to_wb, e_caddr);
        chk("load_fault", 32'(bus.load_fault), 32'(e_fault));
    endtask

    task automatic step();
        #2;
        last_stall = bus.mem_stall;
        chk("mem_stall", 32'(bus.mem_stall), 32'(model_stall()));
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic set_idle();
        bus.M_valid = 0; bus.M_is_load = 0; bus.M_reg_wen = 0; bus.M_rd = '0;
        bus.M_WBSel = '0; bus.M_funct3 = '0; bus.M_PC = '0; bus.M_ALU_out = '0;
        bus.M_csr_reg_en = 0; bus.M_csr_rresult = '0; bus.M_csr_data = '0;
        bus.M_csr_addr = '0; bus.flush = 0; bus.dmem_rvalid = 0; bus.dmem_rdata = '0;
    endtask

    task automatic set_op(input logic ld, input logic [2:0] f3, input logic [31:0] alu,
                          input logic [4:0] rd, input logic [1:0] sel);
        bus.M_valid = 1; bus.M_is_load = ld; bus.M_reg_wen = 1; bus.M_rd = rd;
        bus.M_WBSel = sel; bus.M_funct3 = f3; bus.M_PC = 32'h0000_0100; bus.M_ALU_out = alu;
        bus.M_csr_reg_en = 0; bus.M_csr_rresult = '0; bus.M_csr_data = '0;
        bus.M_csr_addr = '0; bus.flush = 0;
    endtask

    initial begin
        int n_st, n_wr, n_flt;

        rst = 1;
        set_idle();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 0;
        check_all();
        chk("reset_mem_stall", 32'(bus.mem_stall), 32'd0);

        // ADD writes back one cycle later
        set_op(0, 3'b000, 32'h0000_002A, 5'd5, WB_ALU);
        bus.M_PC = 32'h0000_0200;
        step();
        chk("add_stall", 32'(last_stall), 32'd0);
        chk("add_we", 32'(bus.WB_write_enable), 32'd1);
        chk("add_rd", 32'(bus.WB_rd), 32'd5);
        chk("add_alu", bus.WB_ALU_out, 32'h0000_002A);
        set_idle();
        step();
        chk("bubble_we", 32'(bus.WB_write_enable), 32'd0);
        chk("bubble_hold_alu", bus.WB_ALU_out, 32'h0000_002A);

        // Same-cycle loads from a fixed word
        for (int i = 0; i < 5; i++) begin
            set_op(1, lf3[i], 32'h0000_1000 | 32'(loff[i]), 5'd10, WB_DMEM);
            bus.dmem_rvalid = 1;
            bus.dmem_rdata  = 32'h80FF_7F01;
            step();
            chk("imm_load_stall", 32'(last_stall), 32'd0);
            chk("imm_load_dmem", bus.WB_dmem_out, lexp[i]);
        end

        // LW with response three cycles after issue
        set_op(1, F3_LW, 32'h0000_2004, 5'd11, WB_DMEM);
        bus.dmem_rvalid = 0;
        bus.dmem_rdata  = 32'hDEAD_BEEF;
        n_st = 0; n_wr = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_st += int'(last_stall);
            n_wr += int'(bus.WB_write_enable);
        end
        bus.dmem_rvalid = 1;
        step();
        n_st += int'(last_stall);
        n_wr += int'(bus.WB_write_enable);
        chk("lw_dmem", bus.WB_dmem_out, 32'hDEAD_BEEF);
        set_idle();
        step();
        n_wr += int'(bus.WB_write_enable);
        chk("lw_stall_cycles", n_st, 32'd3);
        chk("lw_writes", n_wr, 32'd1);

        // Flush in the second stall cycle, late response is swallowed
        set_op(1, F3_LW, 32'h0000_3000, 5'd12, WB_DMEM);
        bus.dmem_rvalid = 0;
        n_wr = 0;
        step();
        n_wr += int'(bus.WB_write_enable);
        bus.flush = 1;
        step();
        n_wr += int'(bus.WB_write_enable);
        bus.flush = 0;
        for (int i = 0; i < 2; i++) begin
            step();
            n_wr += int'(bus.WB_write_enable);
        end
        bus.dmem_rvalid = 1;
        bus.dmem_rdata  = 32'h1111_2222;
        step();
        n_wr += int'(bus.WB_write_enable);
        set_idle();
        step();
        n_wr += int'(bus.WB_write_enable);
        chk("flush_idle_stall", 32'(last_stall), 32'd0);
        chk("flush_writes", n_wr, 32'd0);

        // Timeout with no response at all
        set_op(1, F3_LW, 32'h0000_4000, 5'd13, WB_DMEM);
        bus.dmem_rvalid = 0;
        n_st = 0; n_wr = 0; n_flt = 0;
        for (int i = 0; i < 22; i++) begin
            step();
            if (!last_stall) set_idle();
            n_st  += int'(last_stall);
            n_wr  += int'(bus.WB_write_enable);
            n_flt += int'(bus.load_fault);
        end
        chk("timeout_stall_cycles", n_st, 32'd16);
        chk("timeout_faults", n_flt, 32'd1);
        chk("timeout_writes", n_wr, 32'd0);
        set_op(0, 3'b000, 32'h0000_0077, 5'd6, WB_ALU);
        step();
        chk("after_timeout_we", 32'(bus.WB_write_enable), 32'd1);
        chk("after_timeout_rd", 32'(bus.WB_rd), 32'd6);

        // CSRRW writeback, then ADD to x0
        set_op(0, 3'b001, 32'h0000_0000, 5'd7, WB_ALU);
        bus.M_csr_reg_en  = 1;
        bus.M_csr_rresult = 32'h0000_1234;
        bus.M_csr_data    = 32'h0000_CAFE;
        bus.M_csr_addr    = 12'h300;
        step();
        chk("csr_stall", 32'(last_stall), 32'd0);
        chk("csr_en", 32'(bus.WB_csr_reg_en), 32'd1);
        chk("csr_addr", bus.WB_csr_addr_to_wb, 32'h0000_0300);
        chk("csr_rresult", bus.WB_csr_rresult, 32'h0000_1234);
        set_op(0, 3'b000, 32'h0000_0055, 5'd0, WB_PC4);
        step();
        chk("rd0_we", 32'(bus.WB_write_enable), 32'd0);

        // Randomized traffic; upstream holds M_* while a load is pending
        for (int i = 0; i < 400; i++) begin
            if (!m_pending) begin
                bus.M_valid       = ($urandom_range(0, 9) < 7);
                bus.M_is_load     = ($urandom_range(0, 1) == 1);
                bus.M_reg_wen     = ($urandom_range(0, 3) != 0);
                bus.M_rd          = 5'($urandom);
                bus.M_WBSel       = 2'($urandom_range(0, 2));
                bus.M_funct3      = 3'($urandom);
                bus.M_PC          = $urandom & 32'hFFFF_FFFC;
                bus.M_ALU_out     = $urandom;
                bus.M_csr_reg_en  = ($urandom_range(0, 3) == 0);
                bus.M_csr_rresult = $urandom;
                bus.M_csr_data    = $urandom;
                bus.M_csr_addr    = 12'($urandom);
            end
            bus.flush       = ($urandom_range(0, 7) == 0);
            bus.dmem_rvalid = ($urandom_range(0, 4) == 0);
            bus.dmem_rdata  = $urandom;
            rst             = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 0;

        // Synchronous reset while a load is waiting
        set_op(1, F3_LW, 32'h0000_5000, 5'd14, WB_DMEM);
        bus.dmem_rvalid = 0;
        step();
        step();
        rst = 1;
        set_idle();
        step();
        rst = 0;
        chk("rstw_stall", 32'(bus.mem_stall), 32'd0);
        chk("rstw_we", 32'(bus.WB_write_enable), 32'd0);
        chk("rstw_alu", bus.WB_ALU_out, 32'd0);
        chk("rstw_pc", bus.WB_PC, 32'd0);
        chk("rstw_fault", 32'(bus.load_fault), 32'd0);
        n_flt = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            n_flt += int'(bus.load_fault);
        end
        chk("rstw_no_late_fault", n_flt, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
